// File: rtl/aes_key_sched_seq_pkg.sv
// ============================================================================
// Module      : aes_key_sched_seq_pkg
// Description : Key-length encodings, Nk/Nr lookups, Rcon table, GF(2^8) mult.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package aes_key_sched_seq_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_e;

  localparam logic [7:0] c_rcon [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_sched_seq_if.sv
// ============================================================================
// Module      : aes_key_sched_seq_if
// Description : Job control and round-key stream bundle of the key scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface aes_key_sched_seq_if #(
  parameter int KEY_W = 256,
  parameter int IDX_W = 4
);
  logic             start;
  logic [1:0]       key_len;
  logic [KEY_W-1:0] key_in;
  logic             rk_valid;
  logic             rk_ready;
  logic [127:0]     rk_data;
  logic [IDX_W-1:0] rk_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, key_len, key_in, rk_ready,
    input  rk_valid, rk_data, rk_idx, busy, done, err
  );

  modport slave (
    input  start, key_len, key_in, rk_ready,
    output rk_valid, rk_data, rk_idx, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/aes_key_sched_seq_subword.sv
// ============================================================================
// Module      : aes_key_sched_seq_subword
// Description : AES SubWord from four combinational S-boxes (inverse + affine).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module aes_key_sched_seq_sbox
  import aes_key_sched_seq_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_inv;

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
  always_comb begin
    logic [7:0] w_sq;
    w_sq  = gf_mul(i_byte, i_byte);
    w_inv = w_sq;
    for (int k = 2; k < 8; k++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;
endmodule

module aes_key_sched_seq_subword (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_key_sched_seq_sbox u_sbox (
      .i_byte (i_word[8*g +: 8]),
      .o_byte (o_word[8*g +: 8])
    );
  end
endmodule

`default_nettype wire

// File: rtl/aes_key_sched_seq.sv
// ============================================================================
// Module      : aes_key_sched_seq
// Description : Word-serial AES-128/192/256 key expansion streaming round keys.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module aes_key_sched_seq
  import aes_key_sched_seq_pkg::*;
#(
  parameter int KEY_W = 256,
  parameter int IDX_W = 4
) (
  input logic                clk,
  input logic                rst,
  aes_key_sched_seq_if.slave bus
);
  state_e      r_state, w_state_nxt;
  key_len_e    r_key_len;
  logic [31:0] r_win [0:7];
  logic [31:0] r_acc [0:2];
  logic [5:0]  r_wcnt;
  logic [2:0]  r_kcnt;
  logic [3:0]  r_rcon_idx;
  logic        r_fin;
  logic        r_rk_valid;
  logic [127:0] r_rk_data;
  logic [IDX_W-1:0] r_rk_idx;
  logic        r_err;

  logic [31:0] w_kw   [0:7];
  logic [31:0] w_load [0:7];
  logic [3:0]  w_in_nk, w_nk, w_nr;
  logic [5:0]  w_last;
  logic [31:0] w_old, w_prev, w_sub_in, w_sub_out, w_word;
  logic [7:0]  w_rc;
  logic        w_is_key, w_kcnt_last, w_start_ok, w_start_bad, w_hs, w_adv, w_done;

  for (genvar k = 0; k < 8; k++) begin : g_kw
    assign w_kw[k] = bus.key_in[KEY_W-1-32*k -: 32];
  end

  // The window is a shift register with w[i-1] at slot 7; the key is loaded
  // into the top Nk slots so the key words rotate out in order w0..w(Nk-1).
  assign w_in_nk = nk_of(key_len_e'(bus.key_len));
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_load[j] = '0;
      if (j >= 8 - int'(w_in_nk)) w_load[j] = w_kw[3'(j - 8 + int'(w_in_nk))];
    end
  end

  assign w_nk        = nk_of(r_key_len);
  assign w_nr        = nr_of(r_key_len);
  assign w_last      = {w_nr, 2'b11};
  assign w_start_ok  = (r_state == ST_IDLE) && bus.start && (key_len_e'(bus.key_len) != KL_BAD);
  assign w_start_bad = (r_state == ST_IDLE) && bus.start && (key_len_e'(bus.key_len) == KL_BAD);
  assign w_prev      = r_win[7];
  assign w_is_key    = r_wcnt < {2'b00, w_nk};
  assign w_kcnt_last = r_kcnt == 3'(w_nk - 4'd1);
  assign w_sub_in    = (r_kcnt == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_rc        = (r_rcon_idx <= 4'd9) ? c_rcon[r_rcon_idx] : 8'h00;

  always_comb begin
    case (r_key_len)
      KL_128:  w_old = r_win[4];
      KL_192:  w_old = r_win[2];
      default: w_old = r_win[0];
    endcase
  end

  aes_key_sched_seq_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_word = w_old ^ w_prev;
    if (w_is_key)
      w_word = w_old;
    else if (r_kcnt == 3'd0)
      w_word = w_old ^ w_sub_out ^ {w_rc, 24'h0};
    else if (r_key_len == KL_256 && r_kcnt == 3'd4)
      w_word = w_old ^ w_sub_out;
  end

  // A round-closing word waits until the output register is free this cycle.
  assign w_hs   = r_rk_valid && bus.rk_ready;
  assign w_adv  = (r_state == ST_GEN) && !r_fin &&
                  ((r_wcnt[1:0] != 2'b11) || !r_rk_valid || bus.rk_ready);
  assign w_done = (r_state == ST_GEN) && r_fin && w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_GEN;
      ST_GEN:  if (w_done)     w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_len  <= KL_128;
      for (int j = 0; j < 8; j++) r_win[j] <= '0;
      for (int j = 0; j < 3; j++) r_acc[j] <= '0;
      r_wcnt     <= '0;
      r_kcnt     <= '0;
      r_rcon_idx <= '0;
      r_fin      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_idx   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_start_ok) begin
        r_key_len  <= key_len_e'(bus.key_len);
        for (int j = 0; j < 8; j++) r_win[j] <= w_load[j];
        r_wcnt     <= '0;
        r_kcnt     <= '0;
        r_rcon_idx <= '0;
        r_fin      <= 1'b0;
      end else if (w_adv) begin
        for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
        r_win[7] <= w_word;
        r_wcnt   <= r_wcnt + 6'd1;
        r_kcnt   <= w_kcnt_last ? 3'd0 : r_kcnt + 3'd1;
        if (!w_is_key && r_kcnt == 3'd0) r_rcon_idx <= r_rcon_idx + 4'd1;
        if (r_wcnt == w_last) r_fin <= 1'b1;
        if (r_wcnt[1:0] != 2'b11) r_acc[r_wcnt[1:0]] <= w_word;
      end
      if (w_adv && r_wcnt[1:0] == 2'b11) begin
        r_rk_valid <= 1'b1;
        r_rk_data  <= {r_acc[0], r_acc[1], r_acc[2], w_word};
        r_rk_idx   <= IDX_W'(r_wcnt[5:2]);
      end else if (w_hs) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  assign bus.rk_valid = r_rk_valid;
  assign bus.rk_data  = r_rk_data;
  assign bus.rk_idx   = r_rk_idx;
  assign bus.busy     = (r_state == ST_GEN);
  assign bus.done     = w_done;
  assign bus.err      = r_err;
endmodule

`default_nettype wire
